// File: rtl/wb_stage.sv
// Writeback stage: load extraction, result select, register-file write port,
// cycle/instret counters and a one-deep registered copy of the last commit.
module wb_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode_MEM,
  input  logic [2:0]      funct3_MEM,
  input  logic [4:0]      instrction_in_MEM,
  input  logic [XLEN-1:0] pc_in_MEM,
  input  logic [XLEN-1:0] alu_in_MEM,
  input  logic [XLEN-1:0] immediate_in_MEM,
  input  logic [XLEN-1:0] dm_rdata_i,
  input  logic [1:0]      wb_sel_MEM,
  input  logic [2:0]      wb_sel_csr_MEM,
  input  logic            reg_write_en_MEM,
  input  logic            wb_stall_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            fwd_valid_o,
  output logic [4:0]      fwd_rd_o,
  output logic [XLEN-1:0] fwd_data_o
);

  logic [63:0]     r_cycle;
  logic [63:0]     r_instret;
  logic            r_fwd_valid;
  logic [4:0]      r_fwd_rd;
  logic [XLEN-1:0] r_fwd_data;

  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_csr;
  logic [XLEN-1:0] w_wdata;
  logic            w_commit;
  logic            w_retire;

  // Load extraction: pick the addressed byte/halfword and extend it.
  always_comb begin
    w_byte = 8'h00;
    unique case (alu_in_MEM[1:0])
      2'd0: w_byte = dm_rdata_i[7:0];
      2'd1: w_byte = dm_rdata_i[15:8];
      2'd2: w_byte = dm_rdata_i[23:16];
      2'd3: w_byte = dm_rdata_i[31:24];
      default: w_byte = 8'h00;
    endcase
    // Halfword select ignores address bit 0.
    w_half = alu_in_MEM[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
    case (funct3_MEM)
      3'b000:  w_load = {{(XLEN - 8){w_byte[7]}}, w_byte};
      3'b100:  w_load = {{(XLEN - 8){1'b0}}, w_byte};
      3'b001:  w_load = {{(XLEN - 16){w_half[15]}}, w_half};
      3'b101:  w_load = {{(XLEN - 16){1'b0}}, w_half};
      default: w_load = dm_rdata_i;
    endcase
  end

  // Counter read select; values are pre-increment, reserved selects read 0.
  always_comb begin
    w_csr = '0;
    case (wb_sel_csr_MEM)
      3'b001:  w_csr = r_cycle[31:0];
      3'b010:  w_csr = r_cycle[63:32];
      3'b011:  w_csr = r_instret[31:0];
      3'b100:  w_csr = r_instret[63:32];
      default: w_csr = '0;
    endcase
  end

  // Result mux; a counter read overrides the normal writeback select.
  always_comb begin
    w_wdata = alu_in_MEM;
    if (wb_sel_csr_MEM != 3'b000) begin
      w_wdata = w_csr;
    end else begin
      unique case (wb_sel_MEM)
        2'b00: w_wdata = alu_in_MEM;
        2'b01: w_wdata = w_load;
        2'b10: w_wdata = pc_in_MEM + 32'd4;
        2'b11: w_wdata = immediate_in_MEM;
        default: w_wdata = alu_in_MEM;
      endcase
    end
  end

  // Commit writes the regfile; retire counts any non-bubble that leaves WB.
  always_comb begin
    w_retire = ~wb_stall_i & (opcode_MEM != 7'd0);
    w_commit = reg_write_en_MEM & w_retire & (instrction_in_MEM != 5'd0);
  end

  // Counters and forwarding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle     <= 64'd0;
      r_instret   <= 64'd0;
      r_fwd_valid <= 1'b0;
      r_fwd_rd    <= 5'd0;
      r_fwd_data  <= '0;
    end else begin
      r_cycle     <= r_cycle + 64'd1;
      if (w_retire) begin
        r_instret <= r_instret + 64'd1;
      end
      r_fwd_valid <= w_commit;
      if (w_commit) begin
        r_fwd_rd   <= instrction_in_MEM;
        r_fwd_data <= w_wdata;
      end
    end
  end

  assign rf_we_o     = w_commit;
  assign rf_waddr_o  = instrction_in_MEM;
  assign rf_wdata_o  = w_wdata;
  assign fwd_valid_o = r_fwd_valid;
  assign fwd_rd_o    = r_fwd_rd;
  assign fwd_data_o  = r_fwd_data;

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage RV32I core, directly downstream of the MEM/WB pipeline register. It consumes the registered MEM/WB fields together with the data-SRAM read word, which bypasses MEM/WB and arrives in the WB cycle. It extracts and extends load data, selects the register-file write value, and drives the register-file write port. It also owns the 64-bit `cycle` and `instret` counters, read via `wb_sel_csr`, and a one-deep registered copy of the last commit for ID-stage forwarding.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `opcode_MEM`  in  7  opcode of the WB instruction; `7'b0` marks a bubble.
- `funct3_MEM`  in  3  load width/sign for loads.
- `instrction_in_MEM`  in  5  destination register rd.
- `pc_in_MEM`  in  32  PC of the WB instruction.
- `alu_in_MEM`  in  32  ALU result; the load byte address for loads.
- `immediate_in_MEM`  in  32  U-type immediate.
- `dm_rdata_i`  in  32  data-SRAM read word at the word-aligned address.
- `wb_sel_MEM`  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate.
- `wb_sel_csr_MEM`  in  3  counter read select: 000 none, 001 cycle[31:0], 010 cycle[63:32], 011 instret[31:0], 100 instret[63:32], 101–111 reserved (read 0).
- `reg_write_en_MEM`  in  1  register write requested.
- `wb_stall_i`  in  1  WB holding the same instruction for another cycle.
- `rf_we_o`  out  1  register-file write enable.
- `rf_waddr_o`  out  5  register-file write address.
- `rf_wdata_o`  out  32  register-file write data.
- `fwd_valid_o`  out  1  registered: last cycle committed a write.
- `fwd_rd_o`  out  5  registered rd of that write.
- `fwd_data_o`  out  32  registered data of that write.

## Operation
- Load extraction uses `off = alu_in_MEM[1:0]`:
  - LB (000): byte `off`, sign-extended.
  - LBU (100): byte `off`, zero-extended.
  - LH (001): halfword `alu_in_MEM[1]`, sign-extended; `alu_in_MEM[0]` is ignored.
  - LHU (101): halfword `alu_in_MEM[1]`, zero-extended; `alu_in_MEM[0]` is ignored.
  - LW (010): full word.
  - Other funct3 values: full word.
- Result mux: if `wb_sel_csr_MEM != 000`, the counter value overrides `wb_sel_MEM`. Otherwise the value is selected per `wb_sel_MEM`; PC+4 uses modulo-2^32 addition.
- Commit condition: `commit = reg_write_en_MEM & ~wb_stall_i & (opcode_MEM != 0) & (instrction_in_MEM != 0)`.
- `rf_we_o = commit`. `rf_waddr_o = instrction_in_MEM` and `rf_wdata_o` are driven every cycle, regardless of commit.
- Retire condition: `retire = ~wb_stall_i & (opcode_MEM != 0)`. This is independent of `reg_write_en`, so stores and branches count.
- `cycle`: 64-bit counter, +1 every cycle when not in reset.
- `instret`: 64-bit counter, +1 on each cycle with `retire`.
- Both counters wrap from 2^64−1 to 0.
- Counter reads return the register value before this cycle's increment. An instruction reading `instret` does not count itself.
- Forwarding register: on each clock edge, `fwd_valid_o <= commit`. When `commit`, also `fwd_rd_o <= rf_waddr_o` and `fwd_data_o <= rf_wdata_o`; otherwise those two hold.

## Timing
- All outputs except `fwd_*` are combinational from the inputs and the counter state.
- Register-file write takes effect at the clock edge ending the WB cycle.
- The `fwd_*` outputs are valid one cycle after commit, covering a regfile read in the same cycle as the write.
- Reset values: `cycle = 0`, `instret = 0`, `fwd_valid_o = 0`, `fwd_rd_o = 0`, `fwd_data_o = 0`.
- The combinational outputs follow from the MEM/WB reset state (all zero): `rf_we_o = 0`, `rf_waddr_o = 0`, `rf_wdata_o = alu = 0`.
- Reset mid-operation: all state clears on the edge where `rst = 1`. Counting resumes on the first edge after `rst` falls, so `cycle` reads 0 in the first post-reset cycle.
- Stall: while `wb_stall_i = 1` there is no write and `instret` holds; `cycle` keeps counting. Deasserting the stall commits and retires the held instruction exactly once.
- Reading `cycle[63:32]` on the cycle the low word wraps returns the pre-carry high word. Software handles this with the standard hi/lo/hi read sequence.

## Test plan
- Load extraction: `dm_rdata_i = 32'h8180_7F01`.
  - LB with off 3 → `32'hFFFF_FF81`.
  - LBU with off 3 → `32'h0000_0081`.
  - LH with off 2 → `32'hFFFF_8180`.
  - LHU with off 0 → `32'h0000_7F01`.
  - LW → `32'h8180_7F01`.
- Mux and x0 suppression:
  - JAL with `pc = 32'hFFFF_FFFC`, `wb_sel = 10` → wdata `0`, we 1.
  - Same instruction with rd = 0 → we 0.
  - `fwd_valid_o` is 0 on the next cycle.
- Counters:
  - 10 cycles after reset release with 6 non-bubble, unstalled instructions → `cycle` read returns 10 and `instret` read returns 6.
  - An `instret` read in the same cycle as a retirement returns the pre-increment value.
- Stall: hold an ADDI (rd = 5, ALU = 7) with `wb_stall_i = 1` for 3 cycles, then release.
  - `rf_we_o` pulses exactly once.
  - `instret` increases by 1.
  - `fwd_rd_o = 5` and `fwd_data_o = 7` on the following cycle.
- Wrap: force the counters to all-ones via a hierarchical deposit.
  - Next cycle: `cycle` and `instret` read 0 in both halves.
  - Reserved select `110` returns 0.
- Reset mid-run: assert `rst` for 1 cycle with nonzero counters and `fwd_valid_o = 1` → all state is 0 on the next cycle.
